// File: rtl/gray_conv_sched_if.sv
// Request/response bundle shared by the Gray-code requesters, the scheduler and the binary consumer.
// A transfer happens on a rising clk edge where valid and ready are both 1; valid never waits on ready.
interface gray_conv_sched_if #(
  parameter int WIDTH = 4,
  parameter int NREQ  = 4
);
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_gray;
  logic [NREQ-1:0]       req_ready;
  logic                  rsp_valid;
  logic [WIDTH-1:0]      rsp_bin;
  logic [IDW-1:0]        rsp_id;
  logic                  rsp_ready;

  modport master (
    output req_valid, req_gray, rsp_ready,
    input  req_ready, rsp_valid, rsp_bin, rsp_id
  );

  modport slave (
    input  req_valid, req_gray, rsp_ready,
    output req_ready, rsp_valid, rsp_bin, rsp_id
  );
endinterface

// File: rtl/gray_conv_sched.sv
// Round-robin scheduler sharing one Gray-to-binary converter among NREQ requesters,
// with a single registered result stage under valid/ready backpressure.
module gray_conv_sched #(
  parameter int WIDTH = 4,
  parameter int NREQ  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  gray_conv_sched_if.slave     bus,
  output logic [15:0]          grant_cnt,
  output logic                 dbg_full
);
  localparam int IDW = $clog2(NREQ);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [IDW-1:0]   ptr_q;
  logic [WIDTH-1:0] bin_q;
  logic [IDW-1:0]   id_q;
  logic [15:0]      cnt_q;

  logic             win_found;
  logic [IDW-1:0]   win_idx;
  logic             can_accept;
  logic             accept;
  logic [WIDTH-1:0] win_gray;
  logic [WIDTH-1:0] win_bin;
  logic [NREQ-1:0]  ready_vec;
  int               scan;

  // Scan from the pointer with wrap; the first valid requester wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan      = 0;
    for (int k = 0; k < NREQ; k++) begin
      scan = int'(ptr_q) + k;
      if (scan >= NREQ) scan = scan - NREQ;
      if (!win_found && bus.req_valid[scan]) begin
        win_found = 1'b1;
        win_idx   = IDW'(scan);
      end
    end
  end

  // A full stage being drained this cycle still takes a new request.
  assign can_accept = (state_q == EMPTY) || bus.rsp_ready;
  assign accept     = !rst && win_found && can_accept;

  always_comb begin
    ready_vec = '0;
    if (accept) ready_vec[win_idx] = 1'b1;
  end

  always_comb begin
    win_gray = bus.req_gray[int'(win_idx)*WIDTH +: WIDTH];
    win_bin  = '0;
    win_bin[WIDTH-1] = win_gray[WIDTH-1];
    for (int i = WIDTH-2; i >= 0; i--) begin
      win_bin[i] = win_bin[i+1] ^ win_gray[i];
    end
  end

  always_comb begin
    state_d = state_q;
    if (accept)                                  state_d = FULL;
    else if (state_q == FULL && bus.rsp_ready)   state_d = EMPTY;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      ptr_q   <= '0;
      bin_q   <= '0;
      id_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        bin_q <= win_bin;
        id_q  <= win_idx;
        ptr_q <= (win_idx == IDW'(NREQ-1)) ? '0 : win_idx + IDW'(1);
        cnt_q <= cnt_q + 16'd1;
      end
    end
  end

  assign bus.req_ready = ready_vec;
  assign bus.rsp_valid = (state_q == FULL);
  assign bus.rsp_bin   = bin_q;
  assign bus.rsp_id    = id_q;
  assign grant_cnt     = cnt_q;
  assign dbg_full      = (state_q == FULL);
endmodule

// File: tb/tb_gray_conv_sched.sv
// Self-checking bench for gray_conv_sched: directed steps plus random traffic against
// a behavioural model (arithmetic Gray decode, modulo round-robin, result queue).
module tb_gray_conv_sched;
  localparam int WIDTH = 4;
  localparam int NREQ  = 4;
  localparam int IDW   = 2;

  logic        clk;
  logic        rst;
  logic [15:0] grant_cnt;
  logic        dbg_full;

  int n_cmp = 0;
  int n_err = 0;

  gray_conv_sched_if #(.WIDTH(WIDTH), .NREQ(NREQ)) bus ();

  gray_conv_sched #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .grant_cnt (grant_cnt),
    .dbg_full  (dbg_full)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // model state
  logic             m_valid;
  logic [WIDTH-1:0] m_bin;
  logic [IDW-1:0]   m_id;
  logic [15:0]      m_cnt;
  int               m_ptr;
  logic [IDW+WIDTH-1:0] exp_q[$];

  function automatic logic [WIDTH-1:0] g2b(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b = g;
    for (int s = 1; s < WIDTH; s++) b = b ^ (g >> s);
    return b;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive at negedge, check combinational ready, advance model at posedge, check registers.
  task automatic cycle(input logic [NREQ-1:0] v, input logic [NREQ*WIDTH-1:0] g,
                       input logic rr, input logic rst_v);
    int win;
    logic acc;
    logic drain;
    logic [NREQ-1:0] exp_ready;
    logic [IDW+WIDTH-1:0] item;
    @(negedge clk);
    rst           = rst_v;
    bus.req_valid = v;
    bus.req_gray  = g;
    bus.rsp_ready = rr;
    #1;
    win = -1;
    for (int k = 0; k < NREQ; k++) begin
      if (win < 0 && v[(m_ptr + k) % NREQ]) win = (m_ptr + k) % NREQ;
    end
    acc       = !rst_v && (win >= 0) && (!m_valid || rr);
    exp_ready = '0;
    if (acc) exp_ready[win] = 1'b1;
    chk("req_ready", 32'(bus.req_ready), 32'(exp_ready));
    drain = m_valid && rr;
    if (drain) begin
      if (exp_q.size() == 0) begin
        chk("sb_underflow", 32'(exp_q.size()), 32'd1);
      end else begin
        item = exp_q.pop_front();
        chk("sb_result", 32'({bus.rsp_id, bus.rsp_bin}), 32'(item));
      end
    end
    @(posedge clk);
    if (rst_v) begin
      m_valid = 1'b0; m_bin = '0; m_id = '0; m_cnt = '0; m_ptr = 0;
      exp_q.delete();
    end else begin
      if (drain) m_valid = 1'b0;
      if (acc) begin
        m_valid = 1'b1;
        m_bin   = g2b(g[win*WIDTH +: WIDTH]);
        m_id    = IDW'(win);
        m_ptr   = (win + 1) % NREQ;
        m_cnt   = m_cnt + 16'd1;
        exp_q.push_back({m_id, m_bin});
      end
    end
    #1;
    chk("rsp_valid", 32'(bus.rsp_valid), 32'(m_valid));
    chk("rsp_bin",   32'(bus.rsp_bin),   32'(m_bin));
    chk("rsp_id",    32'(bus.rsp_id),    32'(m_id));
    chk("grant_cnt", 32'(grant_cnt),     32'(m_cnt));
    chk("dbg_full",  32'(dbg_full),      32'(m_valid));
  endtask

  logic [NREQ*WIDTH-1:0] codes;

  initial begin
    rst = 1'b1; bus.req_valid = '0; bus.req_gray = '0; bus.rsp_ready = 1'b0;
    m_valid = 1'b0; m_bin = '0; m_id = '0; m_cnt = '0; m_ptr = 0;

    // reset state
    cycle('0, '0, 1'b0, 1'b1);
    cycle('0, '0, 1'b0, 1'b1);
    chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("reset_grant_cnt", 32'(grant_cnt), 32'd0);

    // 1: single requester 2, gray 0110
    cycle(4'b0100, {4'b0000, 4'b0110, 4'b0000, 4'b0000}, 1'b1, 1'b0);
    chk("t1_bin", 32'(bus.rsp_bin), 32'h4);
    chk("t1_id",  32'(bus.rsp_id),  32'd2);
    chk("t1_cnt", 32'(grant_cnt),   32'd1);

    // 2: all valid, round-robin with no bubbles
    cycle('0, '0, 1'b1, 1'b1);
    codes = {4'b1101, 4'b1000, 4'b0011, 4'b0000};
    for (int i = 0; i < 8; i++) begin
      cycle(4'b1111, codes, 1'b1, 1'b0);
      chk("t2_id", 32'(bus.rsp_id), 32'(i % NREQ));
      chk("t2_valid", 32'(bus.rsp_valid), 32'd1);
    end

    // 3: backpressure with pointer at 2
    cycle('0, '0, 1'b1, 1'b1);
    cycle(4'b0010, {4'b0, 4'b0, 4'b0111, 4'b0}, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cycle(4'b1001, {4'b0110, 4'b0, 4'b0, 4'b0011}, 1'b0, 1'b0);
      chk("t3_hold_id", 32'(bus.rsp_id), 32'd1);
      chk("t3_hold_bin", 32'(bus.rsp_bin), 32'h5);
    end
    cycle(4'b1001, {4'b0110, 4'b0, 4'b0, 4'b0011}, 1'b1, 1'b0);
    chk("t3_grant3", 32'(bus.rsp_id), 32'd3);
    chk("t3_bin3", 32'(bus.rsp_bin), 32'h4);

    // 4: reset with a pending result and pending requests
    cycle(4'b1111, codes, 1'b0, 1'b1);
    chk("t4_valid", 32'(bus.rsp_valid), 32'd0);
    chk("t4_cnt", 32'(grant_cnt), 32'd0);
    cycle(4'b1010, codes, 1'b1, 1'b0);
    chk("t4_first_id", 32'(bus.rsp_id), 32'd1);

    // 5: exhaustive Gray sweep on requester 0
    for (int i = 0; i < 16; i++) begin
      logic [WIDTH-1:0] gc;
      gc = WIDTH'(i ^ (i >> 1));
      cycle(4'b0001, {12'b0, gc}, 1'b1, 1'b0);
      chk("t5_bin", 32'(bus.rsp_bin), 32'(i));
    end

    // random traffic
    for (int i = 0; i < 400; i++) begin
      cycle(NREQ'($urandom), (NREQ*WIDTH)'($urandom), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 40) == 0));
    end

    // 6: counter wrap
    cycle('0, '0, 1'b1, 1'b1);
    for (int i = 0; i < 65535; i++) begin
      cycle(4'b0100, {4'b0, 4'(i), 4'b0, 4'b0}, 1'b1, 1'b0);
    end
    chk("t6_cnt_max", 32'(grant_cnt), 32'hFFFF);
    cycle(4'b0100, {4'b0, 4'b1011, 4'b0, 4'b0}, 1'b1, 1'b0);
    chk("t6_cnt_wrap", 32'(grant_cnt), 32'h0);
    chk("t6_bin", 32'(bus.rsp_bin), 32'hD);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/gray_conv_sched.md
Name: gray_conv_sched

Overview:
- Round-robin scheduler that shares one Gray-to-binary conversion datapath among NREQ requesters.
- Each requester presents a WIDTH-bit Gray code with a valid/ready handshake.
- The block grants one requester per cycle, converts the code, and returns the binary result tagged with the requester ID through a single registered output stage with valid/ready backpressure.
- Sits between the Gray-coded sources (position counters, async-FIFO pointers) and binary consumers.

Parameters:
- WIDTH, 4, bit width of Gray input and binary result (>=2)
- NREQ, 4, number of requesters (>=2)
- IDW, $clog2(NREQ), width of requester ID; derived, not overridden

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- req_valid  input  NREQ  bit i: requester i presents a code
- req_gray  input  NREQ*WIDTH  requester i code in bits [i*WIDTH +: WIDTH]
- req_ready  output  NREQ  bit i: requester i's code is accepted this cycle (one-hot or zero)
- rsp_valid  output  1  result register holds a valid result
- rsp_bin  output  WIDTH  binary result
- rsp_id  output  IDW  index of the requester that produced rsp_bin
- rsp_ready  input  1  consumer accepts the result this cycle
- grant_cnt  output  16  total accepted requests, wraps modulo 2^16

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high; all state updates on the rising edge of clk.
- Reset values: rsp_valid=0, rsp_bin=0, rsp_id=0, grant_cnt=0, round-robin pointer=0 (requester 0 highest priority). req_ready is 0 while rst=1.
- Conversion (combinational on the granted code):
  - b[WIDTH-1] = g[WIDTH-1]
  - b[i] = b[i+1] XOR g[i] for i = WIDTH-2 down to 0
- Output stage states:
  - EMPTY (rsp_valid=0)
  - FULL (rsp_valid=1)
- Accept condition: can_accept = (state==EMPTY) OR (rsp_ready==1).
  - A FULL stage drained in the same cycle accepts a new request, giving full throughput of 1 result per cycle.
- Arbitration:
  - Scan requesters starting from the round-robin pointer, wrapping modulo NREQ.
  - The first index with req_valid=1 wins.
  - req_ready[winner]=can_accept; all other req_ready bits are 0.
  - req_ready is combinational from req_valid, the pointer, state and rsp_ready.
- On accept (some req_valid[i] & req_ready[i]):
  - rsp_bin <= converted code
  - rsp_id <= i
  - rsp_valid <= 1
  - pointer <= (i+1) mod NREQ
  - grant_cnt <= grant_cnt+1
- Latency: a request accepted in cycle N yields its result with rsp_valid=1 in cycle N+1.
- Drain without accept (rsp_valid & rsp_ready and no request accepted): rsp_valid <= 0. rsp_bin and rsp_id hold their last values.
- Backpressure: while FULL and rsp_ready=0:
  - rsp_bin, rsp_id and rsp_valid hold stable.
  - All req_ready=0.
  - The pointer does not move.
- No valid requests: the pointer does not move and grant_cnt holds.
- Requester contract: a requester may drop req_valid or change req_gray before acceptance. The scheduler samples only in the accept cycle.
- Reset mid-operation: a pending result is discarded (rsp_valid=0 on the next edge). A request presented in the reset cycle is not accepted.
- grant_cnt wrap: 16'hFFFF + 1 -> 16'h0000, with no flag.

Test Plan:
1. After reset, only requester 2 is valid with gray 4'b0110, rsp_ready=1 -> req_ready=4'b0100 that cycle. Next cycle rsp_valid=1, rsp_bin=4'b0100, rsp_id=2, grant_cnt=1.
2. All four valid every cycle, codes 0000/0011/1000/1101, rsp_ready=1 -> grants 0,1,2,3,0,...; results 0000,0010,1111,1001 with ids 0..3 on consecutive cycles, no bubbles.
3. Requester 1 accepted, then rsp_ready held 0 for 5 cycles with requesters 0 and 3 valid -> rsp_bin/rsp_id/rsp_valid stable and req_ready=0 throughout. When rsp_ready rises, requester 3 is granted in that same cycle (pointer was 2).
4. Assert rst for 1 cycle while rsp_valid=1 and requests pending -> next cycle rsp_valid=0, grant_cnt=0, no req_ready during reset. First grant after reset goes to the lowest valid index.
5. Exhaustive: a single requester steps through all 16 Gray codes in sequence -> rsp_bin = 0,1,...,15 in order, one per cycle.
6. Force grant_cnt to 16'hFFFF via 65535 accepts, then one more accept -> grant_cnt=0, conversion unaffected.
